// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the 4:1 mux scan controller: channel count, select
// width, FSM encoding and the next-enabled-channel search.
package mux_scan_ctrl_pkg;

    localparam int NCH = 4;
    localparam int SW  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Lowest set bit of mask at index >= from; returns NCH (bit SW set) if none.
    function automatic logic [SW:0] next_set_bit(input logic [NCH-1:0] mask,
                                                  input int from);
        logic [SW:0] r;
        r = (SW+1)'(NCH);
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i >= from && mask[i]) begin
                r = (SW+1)'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_settle.sv
// Settle counter: cleared by load, counts up to SETTLE while enabled and
// flags done once the select has been held long enough.
module mux_scan_ctrl_settle #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);

    localparam int W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [W-1:0] LAST = W'(SETTLE);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_cnt <= '0;
        end else if (i_en && r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = (r_cnt == LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the 4:1 bit mux: steps sel over the enabled channels,
// samples mux_y after the settle time and offers the assembled word downstream.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           cont,
    input  logic [NCH-1:0] chan_mask,
    output logic [SW-1:0]  sel,
    input  logic           mux_y,
    output logic           busy,
    output logic [NCH-1:0] word,
    output logic           word_valid,
    input  logic           word_ready,
    output logic [1:0]     dbg_state
);

    // Handshake: word is offered while word_valid=1 and is consumed on the
    // clock edge where word_valid=1 and word_ready=1; word_ready is ignored
    // otherwise, and word never changes while word_valid=1.

    state_t         r_state;
    logic [SW-1:0]  r_sel;
    logic [NCH-1:0] r_mask;
    logic [NCH-1:0] r_acc;
    logic [NCH-1:0] r_word;
    logic           r_valid;

    logic [SW:0]    w_first;
    logic [SW:0]    w_next;
    logic [NCH-1:0] w_merged;
    logic           w_done;
    logic           w_load;
    logic           w_accept;

    assign w_first  = next_set_bit(chan_mask, 0);
    assign w_next   = next_set_bit(r_mask, int'(r_sel) + 1);
    assign w_accept = (r_state == ST_HOLD) && word_ready;

    always_comb begin
        w_merged        = r_acc;
        w_merged[r_sel] = mux_y;
        w_merged        = w_merged & r_mask;
    end

    assign w_load = ((r_state == ST_IDLE) && start)
                  || (w_accept && cont)
                  || ((r_state == ST_SCAN) && w_done);

    mux_scan_ctrl_settle #(.SETTLE(SETTLE)) u_settle (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_en   (r_state == ST_SCAN),
        .o_done (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_mask  <= '0;
            r_acc   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mask <= chan_mask;
                        r_acc  <= '0;
                        if (w_first[SW]) begin
                            r_word  <= '0;
                            r_valid <= 1'b1;
                            r_state <= ST_HOLD;
                        end else begin
                            r_sel   <= w_first[SW-1:0];
                            r_state <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (w_done) begin
                        r_acc[r_sel] <= mux_y;
                        if (w_next[SW]) begin
                            r_word  <= w_merged;
                            r_valid <= 1'b1;
                            r_state <= ST_HOLD;
                        end else begin
                            r_sel <= w_next[SW-1:0];
                        end
                    end
                end
                ST_HOLD: begin
                    if (word_ready) begin
                        if (cont) begin
                            r_mask <= chan_mask;
                            r_acc  <= '0;
                            // An empty rescan mask immediately re-offers a zero word.
                            if (w_first[SW]) begin
                                r_word <= '0;
                            end else begin
                                r_valid <= 1'b0;
                                r_sel   <= w_first[SW-1:0];
                                r_state <= ST_SCAN;
                            end
                        end else begin
                            r_valid <= 1'b0;
                            r_sel   <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sel   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign sel        = r_sel;
    assign busy       = (r_state != ST_IDLE);
    assign word       = r_word;
    assign word_valid = r_valid;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance with SETTLE=2 and one with
// SETTLE=0, each fed by a behavioural 4:1 mux model driven by pattern p.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst;

    logic       start, cont, word_ready, mux_y, busy, word_valid;
    logic [3:0] chan_mask, word, p;
    logic [1:0] sel, dbg_state;

    logic       start0, cont0, word_ready0, mux_y0, busy0, word_valid0;
    logic [3:0] chan_mask0, word0, p0;
    logic [1:0] sel0, dbg_state0;

    int n_checks;
    int n_fail;

    mux_scan_ctrl #(.SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .chan_mask(chan_mask),
        .sel(sel), .mux_y(mux_y), .busy(busy), .word(word),
        .word_valid(word_valid), .word_ready(word_ready), .dbg_state(dbg_state)
    );

    mux_scan_ctrl #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .cont(cont0), .chan_mask(chan_mask0),
        .sel(sel0), .mux_y(mux_y0), .busy(busy0), .word(word0),
        .word_valid(word_valid0), .word_ready(word_ready0), .dbg_state(dbg_state0)
    );

    // Behavioural 4:1 mux
    assign mux_y  = p[sel];
    assign mux_y0 = p0[sel0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        start = 0; cont = 0; word_ready = 0; chan_mask = 4'b0000; p = 4'b0000;
        start0 = 0; cont0 = 0; word_ready0 = 0; chan_mask0 = 4'b0000; p0 = 4'b0000;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_sel",   32'(sel), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_word",  32'(word), 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // Reset mid-SCAN
        chan_mask = 4'b1111; p = 4'b1010; start = 1;
        tick();
        start = 0;
        tick(); tick(); tick();
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_sel",  32'(sel), 32'd1);
        rst = 1;
        tick();
        rst = 0;
        check("midrst_sel",   32'(sel), 32'd0);
        check("midrst_busy",  32'(busy), 32'd0);
        check("midrst_valid", 32'(word_valid), 32'd0);
        check("midrst_word",  32'(word), 32'd0);

        // Full scan, mask 1111, p 1010, ready=1
        chan_mask = 4'b1111; p = 4'b1010; word_ready = 1; start = 1;
        tick();
        start = 0;
        check("full_sel0", 32'(sel), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        for (int e = 1; e <= 11; e++) begin
            tick();
            check("full_sel",   32'(sel), 32'(e / 3));
            check("full_valid", 32'(word_valid), 32'd0);
        end
        tick();
        check("full_valid12", 32'(word_valid), 32'd1);
        check("full_word",    32'(word), 32'hA);
        check("full_hold_st", 32'(dbg_state), 32'd2);
        check("full_hold_sel", 32'(sel), 32'd3);
        tick();
        check("full_idle_valid", 32'(word_valid), 32'd0);
        check("full_idle_busy",  32'(busy), 32'd0);
        check("full_idle_sel",   32'(sel), 32'd0);
        check("full_idle_word",  32'(word), 32'hA);

        // Sparse mask 0101, p 1111, start pulses and mask change ignored, then backpressure
        chan_mask = 4'b0101; p = 4'b1111; word_ready = 0; start = 1;
        tick();
        start = 0;
        chan_mask = 4'b1111;
        check("sp_sel0", 32'(sel), 32'd0);
        for (int e = 1; e <= 5; e++) begin
            start = (e == 2 || e == 4);
            tick();
            check("sp_sel",   32'(sel), (e < 3) ? 32'd0 : 32'd2);
            check("sp_valid", 32'(word_valid), 32'd0);
        end
        start = 0;
        tick();
        check("sp_valid6", 32'(word_valid), 32'd1);
        check("sp_word",   32'(word), 32'h5);
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            tick();
            check("bp_valid", 32'(word_valid), 32'd1);
            check("bp_word",  32'(word), 32'h5);
            check("bp_sel",   32'(sel), 32'd2);
        end
        start = 0;
        word_ready = 1;
        tick();
        check("bp_acc_valid", 32'(word_valid), 32'd0);
        check("bp_acc_busy",  32'(busy), 32'd0);

        // Continuous: mask 0011, p 0011 then 0000
        chan_mask = 4'b0011; p = 4'b0011; cont = 1; word_ready = 1; start = 1;
        tick();
        start = 0;
        for (int e = 1; e <= 5; e++) tick();
        check("c1_sel", 32'(sel), 32'd1);
        tick();
        check("c1_valid", 32'(word_valid), 32'd1);
        check("c1_word",  32'(word), 32'h3);
        p = 4'b0000;
        tick();
        check("c2_valid", 32'(word_valid), 32'd0);
        check("c2_busy",  32'(busy), 32'd1);
        check("c2_sel",   32'(sel), 32'd0);
        for (int e = 8; e <= 12; e++) begin
            tick();
            check("c2_word_hold", 32'(word), 32'h3);
            check("c2_nvalid",    32'(word_valid), 32'd0);
        end
        tick();
        check("c2_valid", 32'(word_valid), 32'd1);
        check("c2_word",  32'(word), 32'h0);
        cont = 0;
        tick();
        check("c2_idle", 32'(busy), 32'd0);
        word_ready = 0;

        // SETTLE=0, empty mask, continuous zero words
        chan_mask0 = 4'b0000; cont0 = 1; word_ready0 = 0; start0 = 1;
        tick();
        start0 = 0;
        check("z_valid", 32'(word_valid0), 32'd1);
        check("z_word",  32'(word0), 32'd0);
        check("z_busy",  32'(busy0), 32'd1);
        word_ready0 = 1;
        tick();
        check("z_re_valid", 32'(word_valid0), 32'd1);
        check("z_re_state", 32'(dbg_state0), 32'd2);
        tick();
        check("z_re2_valid", 32'(word_valid0), 32'd1);
        cont0 = 0;
        tick();
        check("z_end_valid", 32'(word_valid0), 32'd0);
        check("z_end_busy",  32'(busy0), 32'd0);

        // SETTLE=0, mask 1011, p 0110: one cycle per channel
        chan_mask0 = 4'b1011; p0 = 4'b0110; word_ready0 = 0; start0 = 1;
        tick();
        start0 = 0;
        check("s0_sel0", 32'(sel0), 32'd0);
        tick();
        check("s0_sel1", 32'(sel0), 32'd1);
        tick();
        check("s0_sel3", 32'(sel0), 32'd3);
        check("s0_nvalid", 32'(word_valid0), 32'd0);
        tick();
        check("s0_valid", 32'(word_valid0), 32'd1);
        check("s0_word",  32'(word0), 32'h2);
        word_ready0 = 1;
        tick();
        check("s0_done", 32'(word_valid0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
